// File: rtl/johnson_pkg.sv
// johnson_pkg
// Shared definitions for the Johnson ring-counter sequencer family:
//   - FSM state encoding (ST_IDLE, ST_RUN)
//   - direction constants (DIR_FWD, DIR_REV)
//   - default ring width and shift-count width
package johnson_pkg;

   localparam int DEF_WIDTH = 5;
   localparam int DEF_CNT_W = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/johnson_phase_dec.sv
// johnson_phase_dec
// Combinational decode of a WIDTH-stage Johnson ring value into its one-hot
// phase index (2*WIDTH phases) plus a legality flag.
// Ports:
//   Q      in   WIDTH      ring value
//   Phase  out  2*WIDTH    one-hot phase index, all-zero when Q is illegal
//   Legal  out  1          Q is one of the 2*WIDTH legal patterns
module johnson_phase_dec #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0]   Q,
   output logic [2*WIDTH-1:0] Phase,
   output logic               Legal
);

   // Pattern for phase k: k ones filling from the LSB for k = 0..WIDTH,
   // then the ones retreat from the LSB for k = WIDTH+1..2*WIDTH-1.
   function automatic logic [WIDTH-1:0] pattern(input int k);
      logic [WIDTH-1:0] p;
      for (int i = 0; i < WIDTH; i++) begin
         p[i] = (k <= WIDTH) ? (i < k) : (i >= k - WIDTH);
      end
      return p;
   endfunction

   always_comb begin
      Phase = '0;
      for (int k = 0; k < 2*WIDTH; k++) begin
         Phase[k] = (Q == pattern(k));
      end
   end

   assign Legal = |Phase;

endmodule

// File: rtl/johnson_phase_ctrl.sv
// johnson_phase_ctrl
// Sequencer for a WIDTH-stage Johnson counter: counted or free-running runs,
// single steps, direction control, preset, and illegal-state recovery.
// Commands are level-sampled strobes; there is no handshake. A command is
// consumed on the rising edge where it is seen, subject to the IDLE/RUN
// priority rules below; commands that do not apply in the current state are
// dropped, not queued.
// Ports:
//   Clk       in   1        rising-edge clock
//   Reset_n   in   1        asynchronous active-low reset
//   Start     in   1        begin a run of Count shifts (IDLE only)
//   Count     in   CNT_W    shifts per run, 0 = free-run until Stop
//   Stop      in   1        abort a run (RUN only)
//   Step      in   1        single shift (IDLE only)
//   Dir       in   1        0 forward, 1 reverse, sampled at each shift
//   Load      in   1        preset ring from LoadVal (IDLE only)
//   LoadVal   in   WIDTH    preset value, may be illegal
//   ErrClr    in   1        clear sticky Err
//   Q         out  WIDTH    ring register
//   Phase     out  2*WIDTH  one-hot phase of Q, zero if Q illegal
//   Busy      out  1        high in RUN
//   Done      out  1        one-cycle pulse on run completion or abort
//   Err       out  1        sticky illegal-state flag
//   DbgState  out  1        current FSM state (state_t encoding)
module johnson_phase_ctrl
   import johnson_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               Start,
   input  logic [CNT_W-1:0]   Count,
   input  logic               Stop,
   input  logic               Step,
   input  logic               Dir,
   input  logic               Load,
   input  logic [WIDTH-1:0]   LoadVal,
   input  logic               ErrClr,
   output logic [WIDTH-1:0]   Q,
   output logic [2*WIDTH-1:0] Phase,
   output logic               Busy,
   output logic               Done,
   output logic               Err,
   output logic               DbgState
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] rem;
   logic             legal;
   logic             shift_en, load_en, rem_load, rem_dec, done_nxt;
   logic [WIDTH-1:0] q_shift;

   johnson_phase_dec #(.WIDTH(WIDTH)) u_dec (
      .Q     (Q),
      .Phase (Phase),
      .Legal (legal)
   );

   // State register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next-state and action decode.
   always_comb begin
      state_nxt = state;
      shift_en  = 1'b0;
      load_en   = 1'b0;
      rem_load  = 1'b0;
      rem_dec   = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (Load) begin
               load_en = 1'b1;
            end else if (Start) begin
               rem_load  = 1'b1;
               state_nxt = ST_RUN;
            end else if (Step) begin
               shift_en = 1'b1;
            end
         end
         ST_RUN: begin
            if (Stop) begin
               state_nxt = ST_IDLE;
               done_nxt  = 1'b1;
            end else begin
               shift_en = 1'b1;
               // rem == 0 means free-run: shift forever, counter untouched.
               if (rem == CNT_W'(1)) begin
                  state_nxt = ST_IDLE;
                  done_nxt  = 1'b1;
               end else if (rem != '0) begin
                  rem_dec = 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decoded from state.
   always_comb begin
      Busy     = (state == ST_RUN);
      DbgState = state;
   end

   assign q_shift = (Dir == DIR_REV) ? {~Q[0], Q[WIDTH-1:1]}
                                     : {Q[WIDTH-2:0], ~Q[WIDTH-1]};

   // Ring register, remaining-shift counter, Done pulse, sticky Err.
   // An illegal ring at a shift edge is forced to phase 0 instead of shifting;
   // that edge still consumes one count.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Q    <= '0;
         rem  <= '0;
         Done <= 1'b0;
         Err  <= 1'b0;
      end else begin
         Done <= done_nxt;
         if (load_en) begin
            Q <= LoadVal;
         end else if (shift_en) begin
            Q <= legal ? q_shift : '0;
         end
         if (rem_load)     rem <= Count;
         else if (rem_dec) rem <= rem - CNT_W'(1);
         // Setting wins over clearing in the same cycle.
         if (shift_en && !legal) Err <= 1'b1;
         else if (ErrClr)        Err <= 1'b0;
      end
   end

endmodule
